la_capture_core: RTL and testbench
==================================

Name: la_capture_core

Overview:
Capture engine of the logic analyzer. It sits directly downstream of the top-level pin wrapper and takes the 8 probe inputs from ui_in. It continuously samples into a circular buffer, detects a masked pattern trigger, and keeps a fixed pre-trigger window. After capture it streams the frozen window out, oldest sample first, over a valid/ready port to the readout/serializer stage.

Parameters:
DEPTH, 32, buffer depth in samples; power of two, 4..64.
WIDTH, 8, probe/sample width.
PRE_TRIG, 8, samples kept before the trigger sample; 0 <= PRE_TRIG <= DEPTH-1.

Ports:
clk  input  1  system clock; all logic rises on this edge.
rst_n  input  1  synchronous active-low reset.
ena  input  1  sampling enable; low freezes sampling and counters, does not affect readout.
arm  input  1  start capture; honoured only in IDLE.
abort  input  1  return to IDLE from any state; higher priority than everything except reset.
sample_in  input  WIDTH  probe inputs, sampled every enabled capture cycle.
trig_mask  input  WIDTH  1 = bit participates in the trigger compare.
trig_value  input  WIDTH  compare value.
rd_valid  output  1  rd_data holds a buffered sample.
rd_ready  input  1  consumer accepts rd_data.
rd_data  output  WIDTH  readout sample.
state  output  3  0 IDLE, 1 PRETRIG, 2 ARMED, 3 POST, 4 READOUT.
triggered  output  1  high from trigger detection until return to IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. Reset forces state=IDLE, rd_valid=0, rd_data=0, triggered=0, and clears wr_ptr, rd_ptr and all counters. Buffer contents are not reset.
- Capture cycle: state is PRETRIG, ARMED or POST and ena=1. Each capture cycle writes sample_in to buf[wr_ptr], then wr_ptr = (wr_ptr+1) mod DEPTH. With ena=0, nothing is written and nothing changes.
- IDLE: when arm=1, wr_ptr=0, pre_cnt=0, and state goes to PRETRIG (to ARMED if PRE_TRIG=0). The first sample is taken on the next edge.
- PRETRIG: triggers are ignored. On the capture cycle that performs the PRE_TRIG-th write, state goes to ARMED.
- ARMED: match = ((sample_in ^ trig_value) & trig_mask) == 0, evaluated on capture cycles only. The matching sample is itself written.
  - On a match: trig_addr = wr_ptr of that write, triggered=1, post_cnt=0.
  - Next state is POST, or READOUT directly if PRE_TRIG = DEPTH-1.
- Mask behaviour: trig_mask=0 triggers on the first ARMED capture cycle.
- POST: after DEPTH-PRE_TRIG-1 further writes, state goes to READOUT with rd_ptr = (trig_addr - PRE_TRIG) mod DEPTH.
- Readout order: buffer index rd_ptr holds the oldest retained sample. The trigger sample appears as the (PRE_TRIG+1)-th transfer.
- READOUT handshake:
  - rd_valid rises on the first cycle in READOUT and rd_data = buf[rd_ptr]. rd_data is registered or combinational from the buffer, but must equal buf[rd_ptr] whenever rd_valid=1.
  - A transfer occurs on rd_valid & rd_ready. rd_ptr increments mod DEPTH and rd_cnt increments.
  - rd_data/rd_valid must stay stable while rd_ready=0.
  - After exactly DEPTH transfers, rd_valid=0 and state=IDLE on the next cycle.
  - rd_ready while rd_valid=0 is ignored.
- arm outside IDLE: ignored.
- abort: from any state, goes to IDLE next cycle with rd_valid=0, triggered=0, counters cleared.
- abort=1 and arm=1 in IDLE simultaneously: stays IDLE.
- Wrap-around: wr_ptr wraps freely in ARMED. While ARMED, older pre-trigger samples are overwritten; only the last PRE_TRIG before the trigger survive.
- Buffer: inferred register array, one write port and one read port, no bypass needed.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles with arm=1 -> state=0, rd_valid=0, triggered=0. Hold rst_n=1 with arm=0 -> stays IDLE.
- Basic capture (DEPTH=32, PRE_TRIG=8): sample_in = incrementing counter starting at 0 from the first capture cycle, mask=FF, value=0x14. Arm -> exactly 32 reads: 0x0C..0x2B, trigger 0x14 at read index 8; state returns to 0.
- Trigger ignored in PRETRIG: value=0x03 with counter stimulus. Counter wraps at 256, next match 0x103&FF -> trigger at sample 259. Readout starts at 259-8=251 (0xFB) and ends at 0x1A, wrapping 0xFF->0x00.
- Masked and immediate trigger: mask=0x00 -> trigger on the 9th sample (counter 8), readout 0x00..0x1F. A second run with mask=0x80, value=0x80 -> trigger sample is 0x80.
- Backpressure and ena gaps: rd_ready toggled randomly and ena low for 3 cycles in ARMED and POST -> no duplicated or skipped samples, rd_data stable while stalled, exactly 32 transfers.
- Abort and re-arm: abort during POST -> IDLE next cycle, triggered=0, rd_valid never rises. Re-arm succeeds with a correct readout. abort during READOUT after 5 transfers -> rd_valid=0 next cycle.

Source files
------------

// File: rtl/la_capture_core_if.sv
// Readout stream between the capture core and the serializer stage.
// The master presents buffered samples; the slave accepts them with rd_ready.
interface la_capture_core_if #(
  parameter int WIDTH = 8
);
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: circular sample buffer with a pre-trigger
// window, masked pattern trigger, and oldest-first valid/ready readout.
module la_capture_core #(
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 8,
  parameter int PRE_TRIG = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                arm,
  input  logic                abort,
  input  logic [WIDTH-1:0]    sample_in,
  input  logic [WIDTH-1:0]    trig_mask,
  input  logic [WIDTH-1:0]    trig_value,
  la_capture_core_if.master   rd,
  output logic [2:0]          state,
  output logic                triggered
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam ptr_t ONE       = ptr_t'(1);
  localparam ptr_t PRE_OFS   = ptr_t'(PRE_TRIG);
  localparam ptr_t PRE_LAST  = ptr_t'(PRE_TRIG - 1);
  localparam ptr_t POST_LAST = ptr_t'(DEPTH - PRE_TRIG - 2);
  localparam ptr_t RD_LAST   = ptr_t'(DEPTH - 1);

  state_t           state_q;
  ptr_t             wr_ptr_q, rd_ptr_q, trig_addr_q;
  ptr_t             pre_cnt_q, post_cnt_q, rd_cnt_q;
  logic             rd_valid_q, triggered_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic capture_d;
  logic match_d;
  ptr_t wr_ptr_d;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    capture_d = 1'b0;
    if (ena && (state_q == S_PRETRIG || state_q == S_ARMED || state_q == S_POST))
      capture_d = 1'b1;
    match_d  = (((sample_in ^ trig_value) & trig_mask) == '0);
    wr_ptr_d = wr_ptr_q + ONE;
  end

  // NOTE: the sample array has no reset; contents are meaningless until written, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (rst_n && !abort && capture_d)
      mem_q[wr_ptr_q] <= sample_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            wr_ptr_q  <= '0;
            pre_cnt_q <= '0;
            state_q   <= (PRE_TRIG == 0) ? S_ARMED : S_PRETRIG;
          end
        end

        S_PRETRIG: begin
          if (ena) begin
            wr_ptr_q  <= wr_ptr_d;
            pre_cnt_q <= pre_cnt_q + ONE;
            if (pre_cnt_q == PRE_LAST)
              state_q <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (ena) begin
            wr_ptr_q <= wr_ptr_d;
            if (match_d) begin
              trig_addr_q <= wr_ptr_q;
              triggered_q <= 1'b1;
              post_cnt_q  <= '0;
              // A full pre-trigger window leaves no post samples to collect.
              if (PRE_TRIG == DEPTH - 1) begin
                state_q    <= S_READOUT;
                rd_ptr_q   <= wr_ptr_q - PRE_OFS;
                rd_cnt_q   <= '0;
                rd_valid_q <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
          end
        end

        S_POST: begin
          if (ena) begin
            wr_ptr_q   <= wr_ptr_d;
            post_cnt_q <= post_cnt_q + ONE;
            if (post_cnt_q == POST_LAST) begin
              state_q    <= S_READOUT;
              rd_ptr_q   <= trig_addr_q - PRE_OFS;
              rd_cnt_q   <= '0;
              rd_valid_q <= 1'b1;
            end
          end
        end

        S_READOUT: begin
          if (rd_valid_q && rd.rd_ready) begin
            rd_ptr_q <= rd_ptr_q + ONE;
            rd_cnt_q <= rd_cnt_q + ONE;
            if (rd_cnt_q == RD_LAST) begin
              rd_valid_q  <= 1'b0;
              triggered_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The buffer is frozen during readout, so a direct read stays stable under stall.
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_valid_q ? mem_q[rd_ptr_q] : '0;
  assign state       = state_q;
  assign triggered   = triggered_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core: counter stimulus, hand-computed readout
// windows, backpressure, enable gaps and abort paths.
module tb_la_capture_core;

  localparam int DEPTH    = 32;
  localparam int WIDTH    = 8;
  localparam int PRE_TRIG = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic [WIDTH-1:0] trig_mask = '0;
  logic [WIDTH-1:0] trig_value = '0;
  logic [2:0]       state;
  logic             triggered;

  int pass_cnt  = 0;
  int total_cnt = 0;

  la_capture_core_if #(.WIDTH(WIDTH)) rd_if ();

  la_capture_core #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .PRE_TRIG (PRE_TRIG)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .arm        (arm),
    .abort      (abort),
    .sample_in  (sample_in),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .rd         (rd_if),
    .state      (state),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Arms the core and feeds an incrementing counter on every enabled cycle
  // until rd_valid rises; optional 3-cycle enable gaps at counter 10 and 30.
  task automatic run_capture(input logic [7:0] mask, input logic [7:0] value,
                             input bit gaps, output bit ok);
    int         cnt;
    int         gap_left;
    bit         g1, g2;
    logic [2:0] exp_gap;
    cnt = 0; gap_left = 0; g1 = 0; g2 = 0; ok = 0; exp_gap = 3'd0;
    trig_mask = mask; trig_value = value; ena = 1'b1; arm = 1'b1;
    tick;
    arm = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (gaps && gap_left == 0 && cnt == 10 && !g1) begin
        gap_left = 3; g1 = 1; exp_gap = 3'd2;
      end else if (gaps && gap_left == 0 && cnt == 30 && !g2) begin
        gap_left = 3; g2 = 1; exp_gap = 3'd3;
      end
      if (gap_left > 0) begin
        ena = 1'b0; sample_in = 8'hEE; gap_left--;
      end else begin
        ena = 1'b1; sample_in = cnt[7:0];
      end
      tick;
      if (ena) cnt++;
      else begin
        total_cnt++;
        if (state !== exp_gap) $display("FAIL gap_state: got %0d want %0d", state, exp_gap);
        else pass_cnt++;
      end
      if (rd_if.rd_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    ena = 1'b1;
    total_cnt++;
    if (!ok) $display("FAIL capture_timeout: rd_valid never rose");
    else if (state !== 3'd4 || triggered !== 1'b1)
      $display("FAIL readout_entry: state=%0d triggered=%b want 4/1", state, triggered);
    else pass_cnt++;
  endtask

  // Drains one full window and compares every presented sample to first+n.
  task automatic readout(input string name, input int first, input bit rand_ready);
    int         n;
    bit         xfer;
    bit         seen;
    logic [7:0] exp_data;
    n = 0;
    for (int cyc = 0; cyc < 400 && n < DEPTH; cyc++) begin
      if (rd_if.rd_valid === 1'b1) begin
        exp_data = 8'(first + n);
        total_cnt++;
        if (rd_if.rd_data !== exp_data)
          $display("FAIL %s_data[%0d]: got %02h want %02h", name, n, rd_if.rd_data, exp_data);
        else pass_cnt++;
      end
      rd_if.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer = (rd_if.rd_valid === 1'b1) && rd_if.rd_ready;
      tick;
      if (xfer) n++;
    end
    rd_if.rd_ready = 1'b0;
    total_cnt++;
    if (n != DEPTH) $display("FAIL %s_count: got %0d want %0d", name, n, DEPTH);
    else pass_cnt++;
    total_cnt++;
    if (rd_if.rd_valid !== 1'b0 || state !== 3'd0 || triggered !== 1'b0)
      $display("FAIL %s_end: valid=%b state=%0d trig=%b want 0/0/0",
               name, rd_if.rd_valid, state, triggered);
    else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (rd_if.rd_valid !== 1'b0) seen = 1;
    end
    rd_if.rd_ready = 1'b0;
    total_cnt++;
    if (seen) $display("FAIL %s_extra: rd_valid=1 got 1 want 0 after window", name);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; arm = 1'b1;
    tick; tick;
    total_cnt++;
    if (state !== 3'd0 || rd_if.rd_valid !== 1'b0 || triggered !== 1'b0 || rd_if.rd_data !== 8'h00)
      $display("FAIL reset: state=%0d valid=%b trig=%b data=%02h want 0/0/0/00",
               state, rd_if.rd_valid, triggered, rd_if.rd_data);
    else pass_cnt++;
    rst_n = 1'b1; arm = 1'b0;
    tick; tick; tick;
    total_cnt++;
    if (state !== 3'd0) $display("FAIL idle_hold: state got %0d want 0", state);
    else pass_cnt++;
    arm = 1'b1; abort = 1'b1;
    tick;
    arm = 1'b0; abort = 1'b0;
    total_cnt++;
    if (state !== 3'd0) $display("FAIL arm_abort_idle: state got %0d want 0", state);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    bit ok;
    run_capture(8'hFF, 8'h14, 1'b0, ok);
    if (ok) readout("basic", 8'h0C, 1'b0);
  endtask

  task automatic test_pretrig_ignore;
    bit ok;
    run_capture(8'hFF, 8'h03, 1'b0, ok);
    if (ok) readout("pretrig", 251, 1'b0);
  endtask

  task automatic test_masked;
    bit ok;
    run_capture(8'h00, 8'h5A, 1'b0, ok);
    if (ok) readout("mask0", 0, 1'b0);
    run_capture(8'h80, 8'h80, 1'b0, ok);
    if (ok) readout("mask80", 120, 1'b0);
  endtask

  task automatic test_backpressure;
    bit ok;
    run_capture(8'hFF, 8'h14, 1'b1, ok);
    if (ok) readout("bp", 8'h0C, 1'b1);
  endtask

  task automatic test_abort;
    bit         ok;
    bit         seen;
    logic [7:0] exp_data;
    // Abort during POST: trigger at 20, 25 writes in.
    trig_mask = 8'hFF; trig_value = 8'h14; ena = 1'b1; arm = 1'b1;
    tick;
    arm = 1'b0;
    for (int cnt = 0; cnt < 25; cnt++) begin
      sample_in = 8'(cnt);
      tick;
    end
    total_cnt++;
    if (state !== 3'd3 || triggered !== 1'b1)
      $display("FAIL pre_abort: state=%0d trig=%b want 3/1", state, triggered);
    else pass_cnt++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total_cnt++;
    if (state !== 3'd0 || triggered !== 1'b0 || rd_if.rd_valid !== 1'b0)
      $display("FAIL abort_post: state=%0d trig=%b valid=%b want 0/0/0",
               state, triggered, rd_if.rd_valid);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      sample_in = 8'(25 + i);
      tick;
      if (rd_if.rd_valid !== 1'b0 || state !== 3'd0) seen = 1;
    end
    total_cnt++;
    if (seen) $display("FAIL abort_quiet: left IDLE or rd_valid rose, want IDLE/0");
    else pass_cnt++;

    run_capture(8'h00, 8'h00, 1'b0, ok);
    if (ok) readout("rearm", 0, 1'b0);

    // Abort during READOUT after 5 transfers.
    run_capture(8'hFF, 8'h14, 1'b0, ok);
    if (ok) begin
      rd_if.rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        exp_data = 8'(8'h0C + i);
        total_cnt++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_data)
          $display("FAIL partial[%0d]: valid=%b data=%02h want 1/%02h",
                   i, rd_if.rd_valid, rd_if.rd_data, exp_data);
        else pass_cnt++;
        tick;
      end
      rd_if.rd_ready = 1'b0;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      total_cnt++;
      if (rd_if.rd_valid !== 1'b0 || state !== 3'd0 || triggered !== 1'b0)
        $display("FAIL abort_readout: valid=%b state=%0d trig=%b want 0/0/0",
                 rd_if.rd_valid, state, triggered);
      else pass_cnt++;
    end

    run_capture(8'h00, 8'h00, 1'b0, ok);
    if (ok) readout("post_abort", 0, 1'b0);
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    test_reset;
    test_basic;
    test_pretrig_ignore;
    test_masked;
    test_backpressure;
    test_abort;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
